// File: rtl/mips32_boot_loader.sv
// Streaming boot loader for the MIPS32 core: writes header/data/checksum image into memory, then releases halt.
// Optional stall timeout is compiled in with `define BOOT_LOADER_TIMEOUT_EN (parameter TIMEOUT_CYC).
module mips32_boot_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
`ifdef BOOT_LOADER_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_halt,
  output logic              cpu_start,
  output logic [ADDR_W-1:0] cpu_pc_init,
  output logic              busy,
  output logic              error,
  output logic [2:0]        dbg_state
);

  // Stream handshake: a word moves on a rising edge where in_valid && in_ready;
  // in_ready depends only on the current state, never on in_valid.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_DATA   = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  localparam logic [16:0] MEM_WORDS = 17'(1 << ADDR_W);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [15:0]         count_q, count_d;
  logic [15:0]         index_q, index_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                start_q, start_d;
  logic [ADDR_W-1:0]   pc_init_q, pc_init_d;
`ifdef BOOT_LOADER_TIMEOUT_EN
  logic [31:0]         tmo_q, tmo_d;
`endif

  logic        active;
  logic        xfer;
  logic [15:0] hdr_base;
  logic [15:0] hdr_count;
  logic [16:0] hdr_end;
  logic        hdr_bad;

  assign active    = (state_q == S_HEADER) || (state_q == S_DATA) || (state_q == S_CHECK);
  assign xfer      = in_valid && active;
  assign hdr_base  = in_data[31:16];
  assign hdr_count = in_data[15:0];
  assign hdr_end   = {1'b0, hdr_base} + {1'b0, hdr_count};
  // Base must fit in ADDR_W bits and the image must not run past the top word.
  assign hdr_bad   = ((hdr_base >> ADDR_W) != 16'd0) || (hdr_end > MEM_WORDS);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    index_d     = index_q;
    sum_d       = sum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    start_d     = 1'b0;
    pc_init_d   = pc_init_q;
`ifdef BOOT_LOADER_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (load_req) state_d = S_HEADER;
      end
      S_HEADER: begin
        if (xfer) begin
          base_d  = hdr_base[ADDR_W-1:0];
          count_d = hdr_count;
          index_d = 16'd0;
          sum_d   = in_data;
          if (hdr_bad)                state_d = S_ERROR;
          else if (hdr_count == 16'd0) state_d = S_CHECK;
          else                         state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = base_q + index_q[ADDR_W-1:0];
          mem_wdata_d = in_data;
          sum_d       = sum_q + in_data;
          index_d     = index_q + 16'd1;
          if (index_d == count_q) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (xfer) begin
          if (in_data == sum_q) begin
            state_d   = S_DONE;
            start_d   = 1'b1;
            pc_init_d = base_q;
          end else begin
            state_d   = S_ERROR;
          end
        end
      end
      S_DONE: begin
        if (load_req) state_d = S_HEADER;
      end
      S_ERROR: begin
        if (load_req) state_d = S_HEADER;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef BOOT_LOADER_TIMEOUT_EN
    // Counts consecutive stalled cycles while the loader is waiting for a word.
    if (state_d == S_HEADER && state_q != S_HEADER) begin
      tmo_d = 32'd0;
    end else if (active) begin
      if (xfer) begin
        tmo_d = 32'd0;
      end else if (tmo_q == 32'(TIMEOUT_CYC - 1)) begin
        tmo_d   = 32'd0;
        state_d = S_ERROR;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      count_q     <= '0;
      index_q     <= '0;
      sum_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      start_q     <= 1'b0;
      pc_init_q   <= '0;
`ifdef BOOT_LOADER_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      index_q     <= index_d;
      sum_q       <= sum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      start_q     <= start_d;
      pc_init_q   <= pc_init_d;
`ifdef BOOT_LOADER_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign in_ready    = active;
  assign busy        = active;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign cpu_halt    = (state_q != S_DONE);
  assign cpu_start   = start_q;
  assign cpu_pc_init = pc_init_q;
  assign error       = (state_q == S_ERROR);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mips32_boot_loader.sv
// Directed bench for mips32_boot_loader: image loads, checksum/range errors, reset and stall behaviour.
module tb_mips32_boot_loader;

  localparam int ADDR_W = 10;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_HEADER = 3'd1, ST_DATA = 3'd2,
                         ST_CHECK = 3'd3, ST_DONE = 3'd4, ST_ERROR = 3'd5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_req = 1'b0;
  logic [31:0]       in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_halt;
  logic              cpu_start;
  logic [ADDR_W-1:0] cpu_pc_init;
  logic              busy;
  logic              error;
  logic [2:0]        dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int start_cnt = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [31:0] mem_img [0:1023];
  logic [31:0] img [0:15];
  logic [31:0] prog [0:7];

  mips32_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_halt(cpu_halt), .cpu_start(cpu_start), .cpu_pc_init(cpu_pc_init),
    .busy(busy), .error(error), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard: every mem_we pulse must match the head of exp_q.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      mem_img[mem_addr] = mem_wdata;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(mem_addr), 64'hffff);
      end else begin
        logic [ADDR_W+31:0] e;
        e = exp_q.pop_front();
        check("mem_write", 64'({mem_addr, mem_wdata}), 64'(e));
      end
    end
    if (rst_n && cpu_start) start_cnt++;
  end

  task automatic pulse_load();
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
  endtask

  task automatic idle_bus();
    @(negedge clk); in_valid = 1'b0; in_data = '0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_stall);
    int n;
    int guard;
    bit rdy;
    n = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
    repeat (n) begin @(negedge clk); in_valid = 1'b0; end
    guard = 0;
    rdy = 1'b0;
    while (!rdy && guard < 200) begin
      @(negedge clk);
      in_data = w; in_valid = 1'b1; rdy = in_ready;
      @(posedge clk);
      guard++;
    end
    if (!rdy) check("ready_timeout", 64'd0, 64'd1);
  endtask

  // Sends header, n words of img[] and the checksum (xor'd with corrupt), queueing expected writes.
  task automatic send_image(input logic [15:0] base, input int n, input int stall,
                            input logic [31:0] corrupt);
    logic [31:0] hdr;
    logic [31:0] sum;
    hdr = {base, 16'(n)};
    sum = hdr;
    send_word(hdr, stall);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({ADDR_W'(base) + ADDR_W'(i), img[i]});
      sum = sum + img[i];
      send_word(img[i], stall);
    end
    send_word(sum ^ corrupt, stall);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prog[0] = 32'h2001_0078; prog[1] = 32'h8C22_0000; prog[2] = 32'h2042_002D;
    prog[3] = 32'hAC22_0001; prog[4] = 32'h2003_0001; prog[5] = 32'h2004_0002;
    prog[6] = 32'h2005_0003; prog[7] = 32'hFC00_0000;
    for (int i = 0; i < 1024; i++) mem_img[i] = '0;

    // Reset values
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_cpu_halt", 64'(cpu_halt), 64'd1);
    check("rst_cpu_start", 64'(cpu_start), 64'd0);
    check("rst_pc_init", 64'(cpu_pc_init), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted mid-DATA
    pulse_load();
    check("t1_state_hdr", 64'(dbg_state), 64'(ST_HEADER));
    check("t1_ready", 64'(in_ready), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    send_word(32'h0010_0004, 0);
    idle_bus();
    check("t1_state_data", 64'(dbg_state), 64'(ST_DATA));
    rst_n = 1'b0;
    #1;
    check("t1_rst_ready", 64'(in_ready), 64'd0);
    check("t1_rst_busy", 64'(busy), 64'd0);
    check("t1_rst_halt", 64'(cpu_halt), 64'd1);
    check("t1_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("t1_post_state", 64'(dbg_state), 64'(ST_IDLE));
    check("t1_post_ready", 64'(in_ready), 64'd0);

    // Single-word image at 120
    start_cnt = 0;
    pulse_load();
    img[0] = 32'h0000_0055;
    send_image(16'h0078, 1, 0, 32'd0);
    idle_bus();
    check("t2_state", 64'(dbg_state), 64'(ST_DONE));
    check("t2_start", 64'(cpu_start), 64'd1);
    check("t2_halt", 64'(cpu_halt), 64'd0);
    check("t2_pc", 64'(cpu_pc_init), 64'd120);
    check("t2_error", 64'(error), 64'd0);
    @(negedge clk);
    check("t2_start_low", 64'(cpu_start), 64'd0);
    @(negedge clk);
    check("t2_start_cnt", 64'(start_cnt), 64'd1);
    check("t2_mem120", 64'(mem_img[120]), 64'h55);
    check("t2_wr_pending", 64'(exp_q.size()), 64'd0);

    // 8-word program at 0
    start_cnt = 0;
    pulse_load();
    for (int i = 0; i < 8; i++) img[i] = prog[i];
    send_image(16'h0000, 8, 0, 32'd0);
    idle_bus();
    check("t3_state", 64'(dbg_state), 64'(ST_DONE));
    check("t3_pc", 64'(cpu_pc_init), 64'd0);
    repeat (2) @(negedge clk);
    check("t3_start_cnt", 64'(start_cnt), 64'd1);
    check("t3_wr_pending", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 8; i++) check("t3_mem", 64'(mem_img[i]), 64'(prog[i]));

    // Bad checksum 0x0078_0057
    start_cnt = 0;
    pulse_load();
    img[0] = 32'h0000_0055;
    send_image(16'h0078, 1, 0, 32'd1);
    idle_bus();
    check("t4_state", 64'(dbg_state), 64'(ST_ERROR));
    check("t4_error", 64'(error), 64'd1);
    check("t4_halt", 64'(cpu_halt), 64'd1);
    repeat (3) @(negedge clk);
    check("t4_start_cnt", 64'(start_cnt), 64'd0);
    pulse_load();
    check("t4_error_clr", 64'(error), 64'd0);
    check("t4_state_hdr", 64'(dbg_state), 64'(ST_HEADER));

    // Range boundaries
    send_word(32'h03FF_0002, 0);
    idle_bus();
    check("t5_range_state", 64'(dbg_state), 64'(ST_ERROR));
    check("t5_range_error", 64'(error), 64'd1);
    pulse_load();
    img[0] = 32'h0000_0007;
    send_image(16'h03FF, 1, 0, 32'd0);
    idle_bus();
    check("t5_top_state", 64'(dbg_state), 64'(ST_DONE));
    check("t5_top_pc", 64'(cpu_pc_init), 64'h3FF);
    @(negedge clk);
    check("t5_mem1023", 64'(mem_img[1023]), 64'd7);
    pulse_load();
    check("t5_relaunch_halt", 64'(cpu_halt), 64'd1);
    check("t5_relaunch_state", 64'(dbg_state), 64'(ST_HEADER));
    send_image(16'h0005, 0, 0, 32'd0);
    idle_bus();
    check("t5_empty_state", 64'(dbg_state), 64'(ST_DONE));
    check("t5_empty_pc", 64'(cpu_pc_init), 64'd5);
    check("t5_wr_pending", 64'(exp_q.size()), 64'd0);

    // Program again with random in_valid gaps
    for (int i = 0; i < 8; i++) mem_img[i] = '0;
    pulse_load();
    for (int i = 0; i < 8; i++) img[i] = prog[i];
    send_image(16'h0000, 8, 3, 32'd0);
    idle_bus();
    check("t6_state", 64'(dbg_state), 64'(ST_DONE));
    check("t6_pc", 64'(cpu_pc_init), 64'd0);
    @(negedge clk);
    check("t6_wr_pending", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 8; i++) check("t6_mem", 64'(mem_img[i]), 64'(prog[i]));

    // load_req ignored in DATA, then a long stall
    pulse_load();
    send_word(32'h0020_0002, 0);
    idle_bus();
    pulse_load();
    check("t7_ignore_req", 64'(dbg_state), 64'(ST_DATA));
`ifdef BOOT_LOADER_TIMEOUT_EN
    repeat (1100) @(negedge clk);
    check("t7_timeout_state", 64'(dbg_state), 64'(ST_ERROR));
    check("t7_timeout_error", 64'(error), 64'd1);
    check("t7_timeout_halt", 64'(cpu_halt), 64'd1);
`else
    repeat (60) @(negedge clk);
    check("t7_stall_state", 64'(dbg_state), 64'(ST_DATA));
    img[0] = 32'hDEAD_BEEF;
    img[1] = 32'h1234_5678;
    exp_q.push_back({10'h020, img[0]});
    exp_q.push_back({10'h021, img[1]});
    send_word(img[0], 0);
    send_word(img[1], 0);
    send_word(32'h0020_0002 + 32'hDEAD_BEEF + 32'h1234_5678, 0);
    idle_bus();
    check("t7_state", 64'(dbg_state), 64'(ST_DONE));
    @(negedge clk);
    check("t7_mem21", 64'(mem_img[33]), 64'h1234_5678);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
